// File: rtl/seg7_to_bcd_capture.sv
// seg7_to_bcd_capture
//   Captures multiplexed 7-segment display samples, decodes them to BCD and
//   publishes a 4-digit frame once it has been seen unchanged for
//   STABLE_FRAMES consecutive complete frames.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high
//   seg_in     : active-low segments, bit6..bit0 = g..a
//   digit_sel  : one-hot digit select, bit0 = least-significant digit
//   sample_en  : seg_in/digit_sel valid this cycle
//   bcd_out    : published digits, [3:0] = digit0 .. [15:12] = digit3
//   err_out    : per-digit invalid-pattern flags of the published frame
//   valid      : one-cycle pulse when bcd_out/err_out update
//   sel_err    : one-cycle pulse after a sample with a bad digit_sel
//   stale      : no accepted sample for TIMEOUT_CYC cycles
//
// FSM
//   state   | meaning
//   COLLECT | filling slots from accepted samples
//   EVAL    | one cycle comparing the latched candidate frame
module seg7_to_bcd_capture #(
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT_CYC   = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  digit_sel,
  input  logic        sample_en,
  output logic [15:0] bcd_out,
  output logic [3:0]  err_out,
  output logic        valid,
  output logic        sel_err,
  output logic        stale
);

  typedef enum logic {COLLECT, EVAL} state_t;

  localparam logic [2:0]  STABLE_N = 3'(STABLE_FRAMES);
  localparam logic [15:0] TIMEOUT  = 16'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] frame_code_q, frame_code_d;
  logic [3:0]  frame_err_q, frame_err_d;
  logic [15:0] cand_code_q, cand_code_d;
  logic [3:0]  cand_err_q, cand_err_d;
  logic [15:0] prev_code_q, prev_code_d;
  logic [3:0]  prev_err_q, prev_err_d;
  logic [2:0]  stable_cnt_q, stable_cnt_d;
  logic        published_q, published_d;
  logic [15:0] pub_code_q, pub_code_d;
  logic [3:0]  pub_err_q, pub_err_d;
  logic        valid_q, valid_d;
  logic        sel_err_q, sel_err_d;
  logic [15:0] idle_q, idle_d;

  logic        sel_onehot, accept, frame_done, do_eval;
  logic [4:0]  dec;
  logic [3:0]  mask_fill;
  logic [2:0]  cnt_next;

  // {err, code}
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      default:    decode = 5'h1F;
    endcase
  endfunction

  assign dec        = decode(seg_in);
  assign sel_onehot = (digit_sel != 4'd0) && ((digit_sel & (digit_sel - 4'd1)) == 4'd0);
  assign accept     = sample_en && sel_onehot;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (frame_done) state_d = EVAL;
      EVAL:    state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    do_eval = (state_q == EVAL);
  end

  // Slot collection; the completing sample is folded into the candidate.
  always_comb begin
    frame_code_d = frame_code_q;
    frame_err_d  = frame_err_q;
    mask_d       = mask_q;
    cand_code_d  = cand_code_q;
    cand_err_d   = cand_err_q;
    mask_fill    = mask_q;
    frame_done   = 1'b0;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (digit_sel[i]) begin
          frame_code_d[i*4 +: 4] = dec[3:0];
          frame_err_d[i]         = dec[4];
        end
      end
      mask_fill = mask_q | digit_sel;
      if (mask_fill == 4'hF) begin
        frame_done  = 1'b1;
        cand_code_d = frame_code_d;
        cand_err_d  = frame_err_d;
        mask_d      = 4'd0;
      end else begin
        mask_d = mask_fill;
      end
    end
  end

  // Stability evaluation and publish. A zero counter means no previous
  // candidate exists yet, so the first frame always loads 1.
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    prev_code_d  = prev_code_q;
    prev_err_d   = prev_err_q;
    published_d  = published_q;
    pub_code_d   = pub_code_q;
    pub_err_d    = pub_err_q;
    valid_d      = 1'b0;
    cnt_next     = 3'd1;
    if (do_eval) begin
      if ((stable_cnt_q != 3'd0) && (cand_code_q == prev_code_q) && (cand_err_q == prev_err_q))
        cnt_next = (stable_cnt_q >= STABLE_N) ? STABLE_N : stable_cnt_q + 3'd1;
      stable_cnt_d = cnt_next;
      prev_code_d  = cand_code_q;
      prev_err_d   = cand_err_q;
      if ((cnt_next == STABLE_N) &&
          (!published_q || (cand_code_q != pub_code_q) || (cand_err_q != pub_err_q))) begin
        pub_code_d  = cand_code_q;
        pub_err_d   = cand_err_q;
        published_d = 1'b1;
        valid_d     = 1'b1;
      end
    end
  end

  always_comb begin
    sel_err_d = sample_en && !sel_onehot;
    if (accept)                idle_d = 16'd0;
    else if (idle_q >= TIMEOUT) idle_d = TIMEOUT;
    else                        idle_d = idle_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q       <= 4'd0;
      frame_code_q <= 16'd0;
      frame_err_q  <= 4'd0;
      cand_code_q  <= 16'd0;
      cand_err_q   <= 4'd0;
      prev_code_q  <= 16'd0;
      prev_err_q   <= 4'd0;
      stable_cnt_q <= 3'd0;
      published_q  <= 1'b0;
      pub_code_q   <= 16'd0;
      pub_err_q    <= 4'd0;
      valid_q      <= 1'b0;
      sel_err_q    <= 1'b0;
      idle_q       <= 16'd0;
    end else begin
      mask_q       <= mask_d;
      frame_code_q <= frame_code_d;
      frame_err_q  <= frame_err_d;
      cand_code_q  <= cand_code_d;
      cand_err_q   <= cand_err_d;
      prev_code_q  <= prev_code_d;
      prev_err_q   <= prev_err_d;
      stable_cnt_q <= stable_cnt_d;
      published_q  <= published_d;
      pub_code_q   <= pub_code_d;
      pub_err_q    <= pub_err_d;
      valid_q      <= valid_d;
      sel_err_q    <= sel_err_d;
      idle_q       <= idle_d;
    end
  end

  assign bcd_out = pub_code_q;
  assign err_out = pub_err_q;
  assign valid   = valid_q;
  assign sel_err = sel_err_q;
  assign stale   = (idle_q == TIMEOUT);

endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// tb_seg7_to_bcd_capture
//   Directed test of seg7_to_bcd_capture with STABLE_FRAMES=2, TIMEOUT_CYC=10.
`timescale 1ns/1ps
module tb_seg7_to_bcd_capture;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  digit_sel;
  logic        sample_en;
  logic [15:0] bcd_out;
  logic [3:0]  err_out;
  logic        valid;
  logic        sel_err;
  logic        stale;

  int n_chk  = 0;
  int n_pass = 0;
  int vcnt   = 0;
  int v0;

  seg7_to_bcd_capture #(.STABLE_FRAMES(2), .TIMEOUT_CYC(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .digit_sel (digit_sel),
    .sample_en (sample_en),
    .bcd_out   (bcd_out),
    .err_out   (err_out),
    .valid     (valid),
    .sel_err   (sel_err),
    .stale     (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) vcnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample(input logic [3:0] sel, input logic [6:0] seg);
    digit_sel = sel;
    seg_in    = seg;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    digit_sel = 4'd0;
  endtask

  task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
    sample(4'b0001, p0);
    sample(4'b0010, p1);
    sample(4'b0100, p2);
    sample(4'b1000, p3);
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; digit_sel = 4'd0; seg_in = 7'h7F;
    #2;
    check("rst_bcd",     32'(bcd_out), 32'h0);
    check("rst_err",     32'(err_out), 32'h0);
    check("rst_valid",   32'(valid),   32'h0);
    check("rst_sel_err", 32'(sel_err), 32'h0);
    check("rst_stale",   32'(stale),   32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // idle timeout
    repeat (9) tick();
    check("stale_9", 32'(stale), 32'h0);
    tick();
    check("stale_10", 32'(stale), 32'h1);
    sample(4'b0001, S1);
    check("stale_clear", 32'(stale), 32'h0);

    // two frames 1,2,3,4 -> publish 4321
    frame(S1, S2, S3, S4);
    tick();
    check("first_frame_no_valid", 32'(valid), 32'h0);
    v0 = vcnt;
    frame(S1, S2, S3, S4);
    check("pub_early", 32'(valid), 32'h0);
    tick();
    check("pub_valid", 32'(valid),   32'h1);
    check("pub_bcd",   32'(bcd_out), 32'h4321);
    check("pub_err",   32'(err_out), 32'h0);
    tick();
    check("pub_valid_end", 32'(valid), 32'h0);
    check("pub_count", 32'(vcnt - v0), 32'd1);

    // one-off different frame, then stable 4321 again -> no republish
    v0 = vcnt;
    frame(S4, S3, S2, S1); tick();
    frame(S1, S2, S3, S4); tick();
    frame(S1, S2, S3, S4); tick(); tick();
    check("glitch_no_valid", 32'(vcnt - v0), 32'd0);
    check("glitch_bcd",      32'(bcd_out),   32'h4321);

    // invalid pattern on digit2, back-to-back frames (sample during EVAL)
    v0 = vcnt;
    frame(S0, S0, SB, S0);
    frame(S0, S0, SB, S0);
    check("blank_early", 32'(valid), 32'h0);
    tick();
    check("blank_valid", 32'(valid),   32'h1);
    check("blank_bcd",   32'(bcd_out), 32'h0F00);
    check("blank_err",   32'(err_out), 32'h4);
    frame(S0, S0, SB, S0); tick(); tick();
    check("blank_once", 32'(vcnt - v0), 32'd1);

    // bad digit_sel, then a frame with a repeat write to digit0
    v0 = vcnt;
    sample(4'b0110, S1);
    check("sel_err_multi", 32'(sel_err), 32'h1);
    tick();
    check("sel_err_multi_end", 32'(sel_err), 32'h0);
    sample(4'b0000, S1);
    check("sel_err_zero", 32'(sel_err), 32'h1);
    tick();
    check("sel_err_zero_end", 32'(sel_err), 32'h0);
    sample(4'b0001, S5);
    sample(4'b0001, S8);
    sample(4'b0010, S8);
    sample(4'b0100, S8);
    sample(4'b1000, S8);
    tick();
    check("ovw_no_valid", 32'(vcnt - v0), 32'd0);
    frame(S8, S8, S8, S8);
    check("ovw_early", 32'(valid), 32'h0);
    tick();
    check("ovw_valid", 32'(valid),   32'h1);
    check("ovw_bcd",   32'(bcd_out), 32'h8888);
    tick();

    // reset mid-frame discards the partial frame
    v0 = vcnt;
    sample(4'b0001, S9);
    sample(4'b0010, S9);
    sample(4'b0100, S9);
    reset = 1'b1;
    #2;
    check("async_rst_bcd",   32'(bcd_out), 32'h0);
    check("async_rst_valid", 32'(valid),   32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    frame(S9, S9, S9, S9);
    sample(4'b0001, S9);
    sample(4'b0010, S9);
    sample(4'b0100, S9);
    check("rst_partial_no_valid", 32'(vcnt - v0), 32'd0);
    sample(4'b1000, S9);
    check("rst_pub_early", 32'(valid), 32'h0);
    tick();
    check("rst_pub_valid", 32'(valid),   32'h1);
    check("rst_pub_bcd",   32'(bcd_out), 32'h9999);
    tick();
    check("rst_pub_count", 32'(vcnt - v0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
